wb_grf: RTL and testbench

- Write-back end of the 5-stage MIPS pipeline and the consumer of the MEM/WB register bundle.
- Selects the write-back data from the W-stage fields and commits it to the 32x32 general register file.
- Serves the two D-stage read ports, with same-cycle W->D bypass so the decode stage never reads a stale value.
- Keeps a retired-instruction counter and a sticky select-error flag for the testbench.

---
 rtl/wb_grf.sv | 120 ++++++++++++
 tb/tb_wb_grf.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_grf.sv
// Write-back stage of the 5-stage MIPS pipeline: selects the W-stage result,
// commits it to the 32x32 register file and serves the two D-stage read ports with W->D bypass.
module wb_grf #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] GP_INIT  = 32'h0000_1800,
  parameter logic [31:0] SP_INIT  = 32'h0000_2FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] W_PC_i,
  input  logic [31:0] W_MemRead_i,
  input  logic [31:0] W_ALUout_i,
  input  logic [31:0] W_HI_i,
  input  logic [31:0] W_LO_i,
  input  logic        W_RegWrite_i,
  input  logic [4:0]  W_RegA3_i,
  input  logic [3:0]  W_RegWDsel_i,
  input  logic [4:0]  D_A1_i,
  input  logic [4:0]  D_A2_i,
  output logic [31:0] D_RD1_o,
  output logic [31:0] D_RD2_o,
  output logic [31:0] W_WD_o,
  output logic        W_we_o,
  output logic [31:0] last_pc_o,
  output logic [31:0] retire_cnt_o,
  output logic        sel_err_o
);

  typedef enum logic [3:0] {
    SEL_ALU = 4'd0,
    SEL_MEM = 4'd1,
    SEL_PC8 = 4'd2,
    SEL_HI  = 4'd3,
    SEL_LO  = 4'd4
  } wd_sel_e;

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] last_pc_q, last_pc_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic        sel_err_q, sel_err_d;
  logic [31:0] wd;
  logic        sel_ok;
  logic        we;

  always_comb begin
    wd     = '0;
    sel_ok = 1'b1;
    case (W_RegWDsel_i)
      SEL_ALU: wd = W_ALUout_i;
      SEL_MEM: wd = W_MemRead_i;
      SEL_PC8: wd = W_PC_i + 32'd8;
      SEL_HI:  wd = W_HI_i;
      SEL_LO:  wd = W_LO_i;
      default: begin
        wd     = '0;
        sel_ok = 1'b0;
      end
    endcase
  end

  // $0 is never written, and an illegal select suppresses the commit entirely
  assign we = W_RegWrite_i & (W_RegA3_i != 5'd0) & sel_ok;

  always_comb begin
    regs_d       = regs_q;
    last_pc_d    = last_pc_q;
    retire_cnt_d = retire_cnt_q;
    sel_err_d    = sel_err_q | (W_RegWrite_i & ~sel_ok);
    if (we) begin
      regs_d[W_RegA3_i] = wd;
      last_pc_d         = W_PC_i;
      retire_cnt_d      = retire_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == 28) ? GP_INIT : ((i == 29) ? SP_INIT : 32'd0);
      end
      last_pc_q    <= PC_RESET;
      retire_cnt_q <= '0;
      sel_err_q    <= 1'b0;
    end else begin
      regs_q       <= regs_d;
      last_pc_q    <= last_pc_d;
      retire_cnt_q <= retire_cnt_d;
      sel_err_q    <= sel_err_d;
    end
  end

  // Same-cycle bypass so decode sees the value being committed this edge
  always_comb begin
    if (D_A1_i == 5'd0) begin
      D_RD1_o = '0;
    end else if (we && (W_RegA3_i == D_A1_i)) begin
      D_RD1_o = wd;
    end else begin
      D_RD1_o = regs_q[D_A1_i];
    end
  end

  always_comb begin
    if (D_A2_i == 5'd0) begin
      D_RD2_o = '0;
    end else if (we && (W_RegA3_i == D_A2_i)) begin
      D_RD2_o = wd;
    end else begin
      D_RD2_o = regs_q[D_A2_i];
    end
  end

  assign W_WD_o       = wd;
  assign W_we_o       = we;
  assign last_pc_o    = last_pc_q;
  assign retire_cnt_o = retire_cnt_q;
  assign sel_err_o    = sel_err_q;

endmodule

// File: tb/tb_wb_grf.sv
// Directed bench for wb_grf: expected values are queued when stimulus is driven
// and popped against DUT outputs; failures are counted by immediate-assertion actions.
module tb_wb_grf;

  logic        clk;
  logic        reset;
  logic [31:0] W_PC_i, W_MemRead_i, W_ALUout_i, W_HI_i, W_LO_i;
  logic        W_RegWrite_i;
  logic [4:0]  W_RegA3_i;
  logic [3:0]  W_RegWDsel_i;
  logic [4:0]  D_A1_i, D_A2_i;
  logic [31:0] D_RD1_o, D_RD2_o, W_WD_o, last_pc_o, retire_cnt_o;
  logic        W_we_o, sel_err_o;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  wb_grf dut (
    .clk          (clk),
    .reset        (reset),
    .W_PC_i       (W_PC_i),
    .W_MemRead_i  (W_MemRead_i),
    .W_ALUout_i   (W_ALUout_i),
    .W_HI_i       (W_HI_i),
    .W_LO_i       (W_LO_i),
    .W_RegWrite_i (W_RegWrite_i),
    .W_RegA3_i    (W_RegA3_i),
    .W_RegWDsel_i (W_RegWDsel_i),
    .D_A1_i       (D_A1_i),
    .D_A2_i       (D_A2_i),
    .D_RD1_o      (D_RD1_o),
    .D_RD2_o      (D_RD2_o),
    .W_WD_o       (W_WD_o),
    .W_we_o       (W_we_o),
    .last_pc_o    (last_pc_o),
    .retire_cnt_o (retire_cnt_o),
    .sel_err_o    (sel_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic expect_val(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic check_output(input logic [31:0] obs);
    exp_t e;
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_empty: observed %h, required a queued expectation", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        tests_failed++;
        $error("[TB] FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic apply_stimulus(input logic we, input logic [4:0] a3, input logic [3:0] sel,
                                input logic [31:0] pc, input logic [31:0] alu);
    W_RegWrite_i = we;
    W_RegA3_i    = a3;
    W_RegWDsel_i = sel;
    W_PC_i       = pc;
    W_ALUout_i   = alu;
  endtask

  task automatic read_check(input logic [4:0] addr, input logic [31:0] exp, input string tag);
    D_A1_i = addr;
    D_A2_i = addr;
    expect_val({tag, "_rd1"}, exp);
    expect_val({tag, "_rd2"}, exp);
    #1;
    check_output(D_RD1_o);
    check_output(D_RD2_o);
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
    W_RegWrite_i = 1'b0;
  endtask

  initial begin
    logic [31:0] sel_exp [5];
    sel_exp[0] = 32'h11;
    sel_exp[1] = 32'h22;
    sel_exp[2] = 32'h3018;
    sel_exp[3] = 32'h33;
    sel_exp[4] = 32'h44;

    reset        = 1'b0;
    W_MemRead_i  = 32'h22;
    W_HI_i       = 32'h33;
    W_LO_i       = 32'h44;
    D_A1_i       = '0;
    D_A2_i       = '0;
    apply_stimulus(1'b0, 5'd0, 4'd0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Dirty some state, then check that a between-edge reset pulse restores everything
    @(negedge clk);
    apply_stimulus(1'b1, 5'd3, 4'd0, 32'h3000, 32'hA5A5_0003);
    @(negedge clk);
    apply_stimulus(1'b1, 5'd28, 4'd0, 32'h3004, 32'h1234_5678);
    @(negedge clk);
    W_RegWrite_i = 1'b0;
    expect_val("pre_reset_cnt", 32'd2);
    #1 check_output(retire_cnt_o);
    reset = 1'b0;
    expect_val("reset_last_pc", 32'h3000);
    expect_val("reset_cnt", 32'd0);
    expect_val("reset_sel_err", 32'd0);
    #1;
    check_output(last_pc_o);
    check_output(retire_cnt_o);
    check_output({31'd0, sel_err_o});
    for (int i = 0; i < 32; i++) begin
      read_check(5'(i), (i == 28) ? 32'h1800 : ((i == 29) ? 32'h2FFC : 32'h0),
                 $sformatf("reset_r%0d", i));
    end
    @(negedge clk);
    reset = 1'b1;

    // Select coverage on $5
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      apply_stimulus(1'b1, 5'd5, 4'(s), 32'h3010, 32'h11);
      post_edge();
      read_check(5'd5, sel_exp[s], $sformatf("sel%0d", s));
    end
    expect_val("sel_cnt", 32'd5);
    expect_val("sel_last_pc", 32'h3010);
    check_output(retire_cnt_o);
    check_output(last_pc_o);

    // Same-cycle bypass on $7
    @(negedge clk);
    apply_stimulus(1'b1, 5'd7, 4'd0, 32'h3020, 32'hDEAD_BEEF);
    read_check(5'd7, 32'hDEAD_BEEF, "bypass_pre");
    expect_val("bypass_we", 32'd1);
    check_output({31'd0, W_we_o});
    post_edge();
    read_check(5'd7, 32'hDEAD_BEEF, "bypass_post");

    // $0 guard
    @(negedge clk);
    apply_stimulus(1'b1, 5'd0, 4'd0, 32'h3024, 32'hFFFF_FFFF);
    read_check(5'd0, 32'h0, "zero_read");
    expect_val("zero_we", 32'd0);
    expect_val("zero_wd", 32'hFFFF_FFFF);
    check_output({31'd0, W_we_o});
    check_output(W_WD_o);
    post_edge();
    expect_val("zero_cnt", 32'd6);
    expect_val("zero_last_pc", 32'h3020);
    check_output(retire_cnt_o);
    check_output(last_pc_o);

    // Illegal select
    @(negedge clk);
    apply_stimulus(1'b1, 5'd9, 4'd7, 32'h3028, 32'h9999_9999);
    expect_val("illegal_we", 32'd0);
    expect_val("illegal_wd", 32'd0);
    expect_val("illegal_err_pre", 32'd0);
    #1;
    check_output({31'd0, W_we_o});
    check_output(W_WD_o);
    check_output({31'd0, sel_err_o});
    post_edge();
    expect_val("illegal_err_post", 32'd1);
    expect_val("illegal_cnt", 32'd6);
    check_output({31'd0, sel_err_o});
    check_output(retire_cnt_o);
    read_check(5'd9, 32'h0, "illegal_r9");
    @(negedge clk);
    apply_stimulus(1'b0, 5'd9, 4'd15, 32'h302C, 32'h0);
    expect_val("sel15_wd", 32'd0);
    #1 check_output(W_WD_o);
    repeat (10) @(negedge clk);
    expect_val("illegal_err_sticky", 32'd1);
    check_output({31'd0, sel_err_o});

    // Counter wrap via hierarchical deposit
    @(negedge clk);
    dut.retire_cnt_q = 32'hFFFF_FFFF;
    apply_stimulus(1'b1, 5'd10, 4'd0, 32'h3030, 32'h55);
    post_edge();
    expect_val("wrap_cnt", 32'd0);
    expect_val("wrap_last_pc", 32'h3030);
    check_output(retire_cnt_o);
    check_output(last_pc_o);
    read_check(5'd10, 32'h55, "wrap_r10");

    // Async reset mid-cycle discards the in-flight write and clears the sticky flag
    @(negedge clk);
    apply_stimulus(1'b1, 5'd11, 4'd0, 32'h3034, 32'h77);
    #2 reset = 1'b0;
    expect_val("midrst_err", 32'd0);
    expect_val("midrst_last_pc", 32'h3000);
    expect_val("midrst_we_comb", 32'd1);
    #1;
    check_output({31'd0, sel_err_o});
    check_output(last_pc_o);
    check_output({31'd0, W_we_o});
    post_edge();
    read_check(5'd11, 32'h0, "midrst_r11");
    read_check(5'd10, 32'h0, "midrst_r10");
    read_check(5'd28, 32'h1800, "midrst_r28");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    expect_val("midrst_cnt", 32'd0);
    check_output(retire_cnt_o);
    read_check(5'd11, 32'h0, "after_rst_r11");

    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_leftover: observed %0d entries, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
